// File: rtl/encoder_priority_4_2.sv
`default_nettype none
// ============================================================================
//  Module   : encoder_priority_4_2
//  Purpose  : 4-to-2 priority encoder with registered outputs. Encodes the
//             index of the winning bit of a 4-bit request vector and flags
//             the no-request case on invalid_input. One cycle of latency,
//             no combinational path from d_in to the outputs.
//  Revision : 1.0  initial release
// ============================================================================
module encoder_priority_4_2 #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d_in,
   output logic       invalid_input,
   output logic [1:0] d_out
);

   localparam logic [1:0] c_IDX_0 = 2'b00;
   localparam logic [1:0] c_IDX_1 = 2'b01;
   localparam logic [1:0] c_IDX_2 = 2'b10;
   localparam logic [1:0] c_IDX_3 = 2'b11;

   logic [1:0] w_enc;
   logic       w_none;
   logic [1:0] r_d_out;
   logic       r_invalid;

   // All-zero request is the only invalid case; multi-hot is always legal.
   assign w_none = (d_in == 4'b0000);

   generate
      if (MSB_FIRST) begin : g_msb_first
         // Highest set bit wins; first matching pattern has priority.
         always_comb begin
            w_enc = c_IDX_0;
            casez (d_in)
               4'b1???: w_enc = c_IDX_3;
               4'b01??: w_enc = c_IDX_2;
               4'b001?: w_enc = c_IDX_1;
               default: w_enc = c_IDX_0;
            endcase
         end
      end else begin : g_lsb_first
         // Lowest set bit wins; mirror image of the MSB-first table.
         always_comb begin
            w_enc = c_IDX_0;
            casez (d_in)
               4'b???1: w_enc = c_IDX_0;
               4'b??10: w_enc = c_IDX_1;
               4'b?100: w_enc = c_IDX_2;
               4'b1000: w_enc = c_IDX_3;
               default: w_enc = c_IDX_0;
            endcase
         end
      end
   endgenerate

   // Output registers; reset overrides any request present on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_d_out   <= c_IDX_0;
         r_invalid <= 1'b1;
      end else begin
         r_d_out   <= w_none ? c_IDX_0 : w_enc;
         r_invalid <= w_none;
      end
   end

   assign d_out         = r_d_out;
   assign invalid_input = r_invalid;

endmodule
`default_nettype wire

// File: tb/tb_encoder_priority_4_2.sv
`default_nettype none
// ============================================================================
//  Module   : tb_encoder_priority_4_2
//  Purpose  : Self-checking bench for encoder_priority_4_2. Both priority
//             orders are instantiated side by side and compared each cycle
//             against an index-search reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_encoder_priority_4_2;

   logic       clk;
   logic       rst_n;
   logic [3:0] d_in;
   logic       inv_m;
   logic [1:0] dout_m;
   logic       inv_l;
   logic [1:0] dout_l;

   int checks;
   int failures;

   encoder_priority_4_2 #(.MSB_FIRST(1'b1)) u_dut_msb (
      .clk           (clk),
      .rst_n         (rst_n),
      .d_in          (d_in),
      .invalid_input (inv_m),
      .d_out         (dout_m)
   );

   encoder_priority_4_2 #(.MSB_FIRST(1'b0)) u_dut_lsb (
      .clk           (clk),
      .rst_n         (rst_n),
      .d_in          (d_in),
      .invalid_input (inv_l),
      .d_out         (dout_l)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {invalid, index}. Searches for the winning bit position.
   function automatic logic [2:0] ref_enc(input logic [3:0] v, input bit msb);
      int idx;
      idx = -1;
      if (msb) begin
         for (int i = 0; i < 4; i++) if (v[i]) idx = i;
      end else begin
         for (int i = 3; i >= 0; i--) if (v[i]) idx = i;
      end
      if (idx < 0) return 3'b100;
      return {1'b0, 2'(idx)};
   endfunction

   task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got {inv,dout}=%b required %b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Apply one input pair, clock it in, then compare both DUTs to the model.
   task automatic tick(input string tag, input logic [3:0] d, input logic r);
      logic [2:0] em;
      logic [2:0] el;
      d_in  = d;
      rst_n = r;
      @(posedge clk);
      #1;
      em = r ? ref_enc(d, 1'b1) : 3'b100;
      el = r ? ref_enc(d, 1'b0) : 3'b100;
      check({tag, "_msb"}, {inv_m, dout_m}, em);
      check({tag, "_lsb"}, {inv_l, dout_l}, el);
   endtask

   logic [3:0] sweep [4];
   logic [3:0] rv;
   logic       rr;

   initial begin
      checks   = 0;
      failures = 0;
      d_in     = 4'b0000;
      rst_n    = 1'b0;

      // Reset dominates an all-ones request for two cycles.
      tick("reset0", 4'b1111, 1'b0);
      tick("reset1", 4'b1111, 1'b0);

      // No request vs single lowest request.
      tick("zero", 4'b0000, 1'b1);
      tick("bit0", 4'b0001, 1'b1);
      check("bit0_const", {inv_m, dout_m}, 3'b000);

      // Single-hot sweep; both priority orders must agree on the index.
      sweep = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int i = 0; i < 4; i++) begin
         tick("onehot", sweep[i], 1'b1);
         check("onehot_const", {inv_m, dout_m}, {1'b0, 2'(i)});
      end

      // Multi-hot patterns from both ends.
      tick("multi_0011", 4'b0011, 1'b1);
      check("m0011_const", {inv_m, dout_m}, 3'b001);
      tick("multi_0110", 4'b0110, 1'b1);
      check("m0110_const_lsb", {inv_l, dout_l}, 3'b001);
      tick("multi_1010", 4'b1010, 1'b1);
      tick("multi_1100", 4'b1100, 1'b1);
      check("m1100_const_lsb", {inv_l, dout_l}, 3'b010);
      tick("multi_1111", 4'b1111, 1'b1);
      check("m1111_const_msb", {inv_m, dout_m}, 3'b011);
      check("m1111_const_lsb", {inv_l, dout_l}, 3'b000);

      // Inputs changing between edges must not reach the outputs.
      d_in = 4'b0000;
      @(negedge clk);
      check("hold_msb", {inv_m, dout_m}, 3'b011);
      check("hold_lsb", {inv_l, dout_l}, 3'b000);

      // Exhaustive count through all request values.
      for (int v = 0; v < 16; v++) tick("exh", 4'(v), 1'b1);

      // Reset asserted mid-stream, then released with request still present.
      tick("stream", 4'b1000, 1'b1);
      tick("midrst", 4'b1000, 1'b0);
      tick("release", 4'b1000, 1'b1);
      check("release_const", {inv_m, dout_m}, 3'b011);

      // Randomized traffic with occasional reset pulses.
      for (int n = 0; n < 300; n++) begin
         rv = 4'($urandom_range(0, 15));
         rr = ($urandom_range(0, 15) != 0);
         tick("rand", rv, rr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
